// File: rtl/demux16_pkg.sv
// Shared constants and types for the demux16_1_reg write side of the 16-entry register bank.
package demux16_pkg;

  localparam int NUM_ENTRIES = 16;
  localparam int WIDTH       = 16;
  localparam int SELW        = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } demux_state_t;

  typedef logic [WIDTH-1:0] entry_t;

endpackage

// File: rtl/dec4_16.sv
// Combinational 4-to-16 one-hot decoder with enable; all-zero output when disabled.
module dec4_16
  import demux16_pkg::*;
(
  input  logic [SELW-1:0]        sel_i,
  input  logic                   en_i,
  output logic [NUM_ENTRIES-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/demux16_1_reg.sv
// Registered 1-to-16 write distributor feeding the mux16_1 read side of a 16-entry bank.
// Optional sequential clear sweep is built only when DEMUX16_CLEAR_EN is defined.
module demux16_1_reg #(
  parameter int WIDTH = demux16_pkg::WIDTH,
  parameter int SELW  = demux16_pkg::SELW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SELW-1:0]  sel,
  input  logic             en,
  output logic             ready,
  input  logic             clr_req,
  output logic             busy,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [WIDTH-1:0] out8,
  output logic [WIDTH-1:0] out9,
  output logic [WIDTH-1:0] out10,
  output logic [WIDTH-1:0] out11,
  output logic [WIDTH-1:0] out12,
  output logic [WIDTH-1:0] out13,
  output logic [WIDTH-1:0] out14,
  output logic [WIDTH-1:0] out15,
  output logic [15:0]      wr_strobe,
  output logic [7:0]       wr_cnt
);
  import demux16_pkg::*;

  logic [WIDTH-1:0]       entry_q [NUM_ENTRIES];
  logic [WIDTH-1:0]       entry_d [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] wrOnehot;
  logic [NUM_ENTRIES-1:0] clrOnehot;
  logic [NUM_ENTRIES-1:0] wrStrobe_q;
  logic [7:0]             wrCnt_q;
  logic [7:0]             wrCnt_d;
  logic                   ready_q;
  logic                   ready_d;
  logic                   busy_q;
  logic                   busy_d;
  logic                   accept;

  assign accept = en & ready_q;

  dec4_16 uWrDec (
    .sel_i    (sel),
    .en_i     (accept),
    .onehot_o (wrOnehot)
  );

`ifdef DEMUX16_CLEAR_EN
  demux_state_t    state_q;
  demux_state_t    state_d;
  logic [SELW-1:0] idx_q;
  logic [SELW-1:0] idx_d;
  logic            sweeping;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == SELW'(NUM_ENTRIES - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign sweeping = (state_q == SWEEP);

  // Clears are never concurrent with writes because ready is low for the whole sweep.
  dec4_16 uClrDec (
    .sel_i    (idx_q),
    .en_i     (sweeping),
    .onehot_o (clrOnehot)
  );

  assign ready_d = (state_d == IDLE);
  assign busy_d  = (state_d == SWEEP);
`else
  logic unusedClrReq;

  assign unusedClrReq = clr_req;
  assign clrOnehot    = '0;
  assign ready_d      = 1'b1;
  assign busy_d       = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      entry_d[i] = entry_q[i];
      if (wrOnehot[i]) begin
        entry_d[i] = in_data;
      end else if (clrOnehot[i]) begin
        entry_d[i] = '0;
      end
    end
    wrCnt_d = accept ? wrCnt_q + 8'd1 : wrCnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entry_q[i] <= '0;
      end
      wrStrobe_q <= '0;
      wrCnt_q    <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entry_q[i] <= entry_d[i];
      end
      wrStrobe_q <= wrOnehot;
      wrCnt_q    <= wrCnt_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign wr_strobe = wrStrobe_q;
  assign wr_cnt    = wrCnt_q;

  assign out0  = entry_q[0];
  assign out1  = entry_q[1];
  assign out2  = entry_q[2];
  assign out3  = entry_q[3];
  assign out4  = entry_q[4];
  assign out5  = entry_q[5];
  assign out6  = entry_q[6];
  assign out7  = entry_q[7];
  assign out8  = entry_q[8];
  assign out9  = entry_q[9];
  assign out10 = entry_q[10];
  assign out11 = entry_q[11];
  assign out12 = entry_q[12];
  assign out13 = entry_q[13];
  assign out14 = entry_q[14];
  assign out15 = entry_q[15];

endmodule

// File: tb/tb_demux16_1_reg.sv
// Directed self-checking bench for demux16_1_reg; sweep scenarios build only with DEMUX16_CLEAR_EN.
module tb_demux16_1_reg;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic [3:0]  sel;
  logic        en;
  logic        ready;
  logic        clr_req;
  logic        busy;
  logic [15:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [15:0] out8, out9, out10, out11, out12, out13, out14, out15;
  logic [15:0] wr_strobe;
  logic [7:0]  wr_cnt;
  logic [15:0] outs [16];

  int total = 0;
  int bad   = 0;

  demux16_1_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .sel       (sel),
    .en        (en),
    .ready     (ready),
    .clr_req   (clr_req),
    .busy      (busy),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4),
    .out5      (out5),
    .out6      (out6),
    .out7      (out7),
    .out8      (out8),
    .out9      (out9),
    .out10     (out10),
    .out11     (out11),
    .out12     (out12),
    .out13     (out13),
    .out14     (out14),
    .out15     (out15),
    .wr_strobe (wr_strobe),
    .wr_cnt    (wr_cnt)
  );

  assign outs[0]  = out0;
  assign outs[1]  = out1;
  assign outs[2]  = out2;
  assign outs[3]  = out3;
  assign outs[4]  = out4;
  assign outs[5]  = out5;
  assign outs[6]  = out6;
  assign outs[7]  = out7;
  assign outs[8]  = out8;
  assign outs[9]  = out9;
  assign outs[10] = out10;
  assign outs[11] = out11;
  assign outs[12] = out12;
  assign outs[13] = out13;
  assign outs[14] = out14;
  assign outs[15] = out15;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge; inputs also change there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n   = 1'b0;
    en      = 1'b0;
    clr_req = 1'b0;
    sel     = 4'h0;
    in_data = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic writeWord(input logic [3:0] s, input logic [15:0] d);
    en      = 1'b1;
    sel     = s;
    in_data = d;
    tick();
    en = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    for (int i = 0; i < 16; i++) begin
      total++;
      if (outs[i] !== 16'h0) begin
        bad++;
        $display("[TB] FAIL reset_out%0d got=%h want=0000", i, outs[i]);
      end
    end
    total++;
    if (wr_strobe !== 16'h0) begin
      bad++;
      $display("[TB] FAIL reset_strobe got=%h want=0000", wr_strobe);
    end
    total++;
    if (wr_cnt !== 8'h0) begin
      bad++;
      $display("[TB] FAIL reset_cnt got=%0d want=0", wr_cnt);
    end
    total++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_ready_busy got=%b%b want=10", ready, busy);
    end
  endtask

  task automatic test_write_entry10();
    doReset();
    writeWord(4'hA, 16'h00AB);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (outs[i] !== ((i == 10) ? 16'h00AB : 16'h0000)) begin
        bad++;
        $display("[TB] FAIL wr10_out%0d got=%h want=%h", i, outs[i],
                 (i == 10) ? 16'h00AB : 16'h0000);
      end
    end
    total++;
    if (wr_strobe !== 16'h0400) begin
      bad++;
      $display("[TB] FAIL wr10_strobe got=%h want=0400", wr_strobe);
    end
    total++;
    if (wr_cnt !== 8'd1) begin
      bad++;
      $display("[TB] FAIL wr10_cnt got=%0d want=1", wr_cnt);
    end
    tick();
    total++;
    if (wr_strobe !== 16'h0 || wr_cnt !== 8'd1 || out10 !== 16'h00AB) begin
      bad++;
      $display("[TB] FAIL wr10_idle got strobe=%h cnt=%0d out10=%h want 0000/1/00ab",
               wr_strobe, wr_cnt, out10);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] expStrobe;
    doReset();
    for (int i = 0; i < 16; i++) begin
      en      = 1'b1;
      sel     = 4'(i);
      in_data = 16'(i);
      tick();
      expStrobe = 16'h1 << i;
      total++;
      if (wr_strobe !== expStrobe || wr_cnt !== 8'(i + 1)) begin
        bad++;
        $display("[TB] FAIL fill_step%0d got strobe=%h cnt=%0d want %h/%0d",
                 i, wr_strobe, wr_cnt, expStrobe, i + 1);
      end
    end
    en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (outs[i] !== 16'(i)) begin
        bad++;
        $display("[TB] FAIL fill_out%0d got=%h want=%h", i, outs[i], 16'(i));
      end
    end
    // mux16_1 read side with sel = 4'hA
    total++;
    if (outs[4'hA] !== 16'h000A) begin
      bad++;
      $display("[TB] FAIL fill_mux_read got=%h want=000a", outs[4'hA]);
    end
  endtask

  task automatic test_wrap_hold();
    doReset();
    en = 1'b1;
    for (int i = 0; i < 255; i++) begin
      sel     = 4'(i);
      in_data = 16'(i ^ 16'h5A5A);
      tick();
    end
    total++;
    if (wr_cnt !== 8'd255) begin
      bad++;
      $display("[TB] FAIL wrap_cnt255 got=%0d want=255", wr_cnt);
    end
    sel     = 4'h2;
    in_data = 16'hBEEF;
    tick();
    en = 1'b0;
    total++;
    if (wr_cnt !== 8'd0 || wr_strobe !== 16'h0004 || out2 !== 16'hBEEF) begin
      bad++;
      $display("[TB] FAIL wrap_cnt0 got cnt=%0d strobe=%h out2=%h want 0/0004/beef",
               wr_cnt, wr_strobe, out2);
    end
    tick();
    total++;
    if (wr_strobe !== 16'h0 || wr_cnt !== 8'd0) begin
      bad++;
      $display("[TB] FAIL hold_idle got strobe=%h cnt=%0d want 0000/0", wr_strobe, wr_cnt);
    end
  endtask

`ifndef DEMUX16_CLEAR_EN
  task automatic test_clr_ignored();
    doReset();
    writeWord(4'h5, 16'h5555);
    clr_req = 1'b1;
    en      = 1'b1;
    sel     = 4'h6;
    in_data = 16'h6666;
    tick();
    total++;
    if (ready !== 1'b1 || busy !== 1'b0 || out6 !== 16'h6666 || wr_cnt !== 8'd2) begin
      bad++;
      $display("[TB] FAIL clr_ignored_write got r=%b b=%b out6=%h cnt=%0d want 1/0/6666/2",
               ready, busy, out6, wr_cnt);
    end
    en = 1'b0;
    repeat (18) tick();
    clr_req = 1'b0;
    total++;
    if (out5 !== 16'h5555 || out6 !== 16'h6666 || ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL clr_ignored_hold got out5=%h out6=%h r=%b b=%b want 5555/6666/1/0",
               out5, out6, ready, busy);
    end
  endtask
`else
  task automatic fillBank();
    for (int i = 0; i < 16; i++) begin
      writeWord(4'(i), 16'(i));
    end
  endtask

  task automatic test_sweep();
    doReset();
    fillBank();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    en      = 1'b1;
    sel     = 4'h7;
    in_data = 16'hFFFF;
    for (int k = 1; k <= 16; k++) begin
      total++;
      if (ready !== 1'b0 || busy !== 1'b1 || wr_strobe !== 16'h0) begin
        bad++;
        $display("[TB] FAIL sweep_flags_T+%0d got r=%b b=%b strobe=%h want 0/1/0000",
                 k - 1, ready, busy, wr_strobe);
      end
      tick();
      if (k == 6) begin
        total++;
        if (out5 !== 16'h0 || out6 !== 16'h6) begin
          bad++;
          $display("[TB] FAIL sweep_T+6 got out5=%h out6=%h want 0000/0006", out5, out6);
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (outs[i] !== 16'h0) begin
        bad++;
        $display("[TB] FAIL sweep_done_out%0d got=%h want=0000", i, outs[i]);
      end
    end
    total++;
    if (ready !== 1'b1 || busy !== 1'b0 || wr_cnt !== 8'd16) begin
      bad++;
      $display("[TB] FAIL sweep_end got r=%b b=%b cnt=%0d want 1/0/16", ready, busy, wr_cnt);
    end
    tick();
    en = 1'b0;
    total++;
    if (out7 !== 16'hFFFF || wr_cnt !== 8'd17) begin
      bad++;
      $display("[TB] FAIL sweep_T+17 got out7=%h cnt=%0d want ffff/17", out7, wr_cnt);
    end
  endtask

  task automatic test_write_and_clear();
    doReset();
    en      = 1'b1;
    sel     = 4'h3;
    in_data = 16'h1234;
    clr_req = 1'b1;
    tick();
    en      = 1'b0;
    clr_req = 1'b0;
    total++;
    if (out3 !== 16'h1234 || wr_cnt !== 8'd1 || ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL wrclr_T got out3=%h cnt=%0d r=%b want 1234/1/0", out3, wr_cnt, ready);
    end
    repeat (3) tick();
    total++;
    if (out3 !== 16'h1234) begin
      bad++;
      $display("[TB] FAIL wrclr_T+3 got=%h want=1234", out3);
    end
    tick();
    total++;
    if (out3 !== 16'h0) begin
      bad++;
      $display("[TB] FAIL wrclr_T+4 got=%h want=0000", out3);
    end
  endtask

  task automatic test_reset_abort();
    doReset();
    fillBank();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (8) tick();
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (outs[i] !== 16'h0) begin
        bad++;
        $display("[TB] FAIL abort_out%0d got=%h want=0000", i, outs[i]);
      end
    end
    total++;
    if (ready !== 1'b1 || busy !== 1'b0 || wr_cnt !== 8'd0 || wr_strobe !== 16'h0) begin
      bad++;
      $display("[TB] FAIL abort_flags got r=%b b=%b cnt=%0d strobe=%h want 1/0/0/0000",
               ready, busy, wr_cnt, wr_strobe);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    writeWord(4'h9, 16'h0909);
    total++;
    if (ready !== 1'b1 || busy !== 1'b0 || out9 !== 16'h0909) begin
      bad++;
      $display("[TB] FAIL abort_release got r=%b b=%b out9=%h want 1/0/0909", ready, busy, out9);
    end
  endtask
`endif

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    clr_req = 1'b0;
    sel     = 4'h0;
    in_data = 16'h0;
    $display("[TB] starting demux16_1_reg bench");
    test_reset();
    test_write_entry10();
    test_back_to_back();
    test_wrap_hold();
`ifndef DEMUX16_CLEAR_EN
    test_clr_ignored();
`else
    test_sweep();
    test_write_and_clear();
    test_reset_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
